// File: rtl/hline_sched_if.sv
// Descriptor push port and engine launch/completion port of the hline span scheduler.
// The scheduler takes the master view; software and the engine together take the slave view.
interface hline_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_fb_addr;
  logic [31:0] cmd_zbuff_addr;
  logic [31:0] cmd_dx;
  logic [31:0] cmd_slope;
  logic [31:0] cmd_z1;
  logic [31:0] cmd_rem;
  logic [31:0] cmd_err;
  logic [31:0] cmd_rgbx;

  logic        eng_start;
  logic [31:0] eng_fb_addr;
  logic [31:0] eng_zbuff_addr;
  logic [31:0] eng_dx;
  logic [31:0] eng_slope;
  logic [31:0] eng_z1;
  logic [31:0] eng_rem;
  logic [31:0] eng_err;
  logic [31:0] eng_rgbx;
  logic        eng_done;
  logic [31:0] eng_z_sum;

  modport master (
    input  cmd_valid, cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope, cmd_z1, cmd_rem,
           cmd_err, cmd_rgbx, eng_done, eng_z_sum,
    output cmd_ready, eng_start, eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1,
           eng_rem, eng_err, eng_rgbx
  );

  modport slave (
    output cmd_valid, cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope, cmd_z1, cmd_rem,
           cmd_err, cmd_rgbx, eng_done, eng_z_sum,
    input  cmd_ready, eng_start, eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1,
           eng_rem, eng_err, eng_rgbx
  );
endinterface

// File: rtl/hline_sched.sv
// Span scheduler for the hline z-buffer engine: descriptor FIFO, one-span-at-a-time launch,
// done-level completion detect, retire bookkeeping and a launch-to-done watchdog.
module hline_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  hline_sched_if.master          bus,
  input  logic                   err_clr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_level,
  output logic [15:0]            spans_done,
  output logic [31:0]            last_z_sum,
  output logic                   timeout_err
);
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitAck,
    StWaitDone,
    StRetire,
    StHalt
  } state_e;

  state_e          state_q;
  logic [255:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   level_q, level_d;
  logic [255:0]    eng_q;
  logic            eng_start_q;
  logic [31:0]     wd_q;
  logic [15:0]     spans_q;
  logic [31:0]     last_z_q;
  logic            timeout_err_q;
  logic            push, pop, wd_expired;

  // Ready comes from the registered level only, so a same-cycle pop never raises it.
  assign bus.cmd_ready = (level_q != LevelFull);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = (state_q == StIdle) && (level_q != '0);
  assign level_d       = level_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
  assign wd_expired    = (TIMEOUT != 0) && (wd_q == TIMEOUT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_fb_addr, bus.cmd_zbuff_addr, bus.cmd_dx, bus.cmd_slope,
                          bus.cmd_z1, bus.cmd_rem, bus.cmd_err, bus.cmd_rgbx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      eng_q         <= '0;
      eng_start_q   <= 1'b0;
      wd_q          <= '0;
      spans_q       <= '0;
      last_z_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            eng_q       <= mem_q[rd_ptr_q];
            eng_start_q <= 1'b1;
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          wd_q    <= '0;
          state_q <= StWaitAck;
        end
        // The previous span leaves done high; wait for the engine to drop it first.
        StWaitAck: begin
          wd_q <= wd_q + 32'd1;
          if (wd_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= StHalt;
          end else if (!bus.eng_done) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          wd_q <= wd_q + 32'd1;
          if (wd_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= StHalt;
          end else if (bus.eng_done) begin
            state_q <= StRetire;
          end
        end
        StRetire: begin
          last_z_q <= bus.eng_z_sum;
          spans_q  <= spans_q + 16'd1;
          state_q  <= StIdle;
        end
        StHalt: begin
          if (err_clr) begin
            timeout_err_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.eng_start      = eng_start_q;
  assign bus.eng_fb_addr    = eng_q[255:224];
  assign bus.eng_zbuff_addr = eng_q[223:192];
  assign bus.eng_dx         = eng_q[191:160];
  assign bus.eng_slope      = eng_q[159:128];
  assign bus.eng_z1         = eng_q[127:96];
  assign bus.eng_rem        = eng_q[95:64];
  assign bus.eng_err        = eng_q[63:32];
  assign bus.eng_rgbx       = eng_q[31:0];

  assign busy        = (state_q == StLaunch) || (state_q == StWaitAck) ||
                       (state_q == StWaitDone);
  assign queue_level = level_q;
  assign spans_done  = spans_q;
  assign last_z_sum  = last_z_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_hline_sched.sv
// Directed bench for hline_sched with a simple engine model (done = start + delay cycles,
// z sum = z1 + dx) and a manual done override for stale-done and stall scenarios.
module tb_hline_sched;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        busy;
  logic [2:0]  queue_level;
  logic [15:0] spans_done;
  logic [31:0] last_z_sum;
  logic        timeout_err;

  hline_sched_if bus ();

  hline_sched #(
    .DEPTH  (Depth),
    .TIMEOUT(Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err_clr    (err_clr),
    .busy       (busy),
    .queue_level(queue_level),
    .spans_done (spans_done),
    .last_z_sum (last_z_sum),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Engine model plus manual override of done / z sum.
  logic        model_en, hang, man_done, m_done, m_run;
  logic [31:0] man_z, m_z;
  int unsigned delay, m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0;
      m_z    <= '0;
      m_run  <= 1'b0;
      m_cnt  <= 0;
    end else if (model_en && bus.eng_start) begin
      m_done <= 1'b0;
      m_run  <= 1'b1;
      m_cnt  <= 1;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (!hang && m_cnt == delay - 1) begin
        m_done <= 1'b1;
        m_z    <= bus.eng_z1 + bus.eng_dx;
        m_run  <= 1'b0;
      end
    end
  end

  assign bus.eng_done  = model_en ? m_done : man_done;
  assign bus.eng_z_sum = model_en ? m_z : man_z;

  int unsigned starts = 0;
  logic [31:0] rgbx_log [$];
  always @(posedge clk) begin
    if (bus.eng_start) begin
      starts <= starts + 1;
      rgbx_log.push_back(bus.eng_rgbx);
    end
  end

  logic [255:0] eng_all;
  assign eng_all = {bus.eng_fb_addr, bus.eng_zbuff_addr, bus.eng_dx, bus.eng_slope,
                    bus.eng_z1, bus.eng_rem, bus.eng_err, bus.eng_rgbx};

  int          checks = 0;
  int          errors = 0;
  int unsigned s0;
  logic [255:0] exp_d;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [255:0] desc(input logic [31:0] rgbx, dx, z1);
    return {32'hF000_0000 | rgbx, 32'hE000_0000 | rgbx, dx, 32'h5100_0000 | rgbx, z1,
            32'h7E00_0000 | rgbx, 32'hEE00_0000 | rgbx, rgbx};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cmd(input logic [31:0] rgbx, dx, z1);
    {bus.cmd_fb_addr, bus.cmd_zbuff_addr, bus.cmd_dx, bus.cmd_slope, bus.cmd_z1, bus.cmd_rem,
     bus.cmd_err, bus.cmd_rgbx} = desc(rgbx, dx, z1);
  endtask

  task automatic push(input logic [31:0] rgbx, dx, z1);
    set_cmd(rgbx, dx, z1);
    bus.cmd_valid = 1'b1;
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_level"}, queue_level, 0);
    check({pfx, "_ready"}, bus.cmd_ready, 1);
    check({pfx, "_start"}, bus.eng_start, 0);
    check({pfx, "_eng"}, eng_all, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_spans"}, spans_done, 0);
    check({pfx, "_lastz"}, last_z_sum, 0);
    check({pfx, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; err_clr = 1'b0; bus.cmd_valid = 1'b0; set_cmd(0, 0, 0);
    model_en = 1'b1; hang = 1'b0; delay = 40; man_done = 1'b0; man_z = '0;
    cyc(2);
    check_reset_values("rst");
    reset = 1'b0;
    cyc();

    // Single span: start 2 cycles after push, done 40 cycles after start.
    s0 = starts;
    push(32'h11, 32'd300, 32'h100);
    check("ss_level_pre_pop", queue_level, 1);
    cyc();
    check("ss_start", bus.eng_start, 1);
    check("ss_desc", eng_all, desc(32'h11, 32'd300, 32'h100));
    check("ss_level_popped", queue_level, 0);
    cyc();
    check("ss_start_one_cycle", bus.eng_start, 0);
    cyc(39);
    check("ss_busy_at_done", busy, 1);
    check("ss_spans_pre", spans_done, 0);
    cyc();
    check("ss_busy_retire", busy, 0);
    cyc();
    check("ss_spans", spans_done, 1);
    check("ss_zsum", last_z_sum, 32'h22C);
    check("ss_starts", starts - s0, 1);

    // Stale done held high from the previous span.
    man_done = 1'b1; man_z = 32'hDEAD; model_en = 1'b0;
    push(32'h21, 32'd7, 32'd9);
    cyc(10);
    check("st_held_busy", busy, 1);
    check("st_no_retire", spans_done, 1);
    man_done = 1'b0;
    cyc(3);
    check("st_low_busy", busy, 1);
    check("st_low_spans", spans_done, 1);
    man_done = 1'b1;
    cyc(2);
    check("st_spans", spans_done, 2);
    check("st_zsum", last_z_sum, 32'hDEAD);

    // Fill and backpressure behind a stalled span.
    push(32'h30, 32'd1, 32'd1);
    for (int i = 1; i <= 4; i++) push(i, i, 32'h1000);
    check("bp_full_level", queue_level, 4);
    check("bp_full_ready", bus.cmd_ready, 0);
    set_cmd(5, 5, 32'h1000);
    bus.cmd_valid = 1'b1;
    cyc(3);
    check("bp_hold_level", queue_level, 4);
    check("bp_hold_ready", bus.cmd_ready, 0);
    man_done = 1'b0;
    cyc();
    man_done = 1'b1;
    cyc(2);
    model_en = 1'b1; delay = 5; rgbx_log.delete();
    check("bp_stall_retired", spans_done, 3);
    check("bp_level_pre_pop", queue_level, 4);
    check("bp_ready_pre_pop", bus.cmd_ready, 0);
    cyc();
    check("bp_level_popped", queue_level, 3);
    check("bp_ready_after_pop", bus.cmd_ready, 1);
    check("bp_first_rgbx", bus.eng_rgbx, 1);
    cyc();
    bus.cmd_valid = 1'b0;
    check("bp_fifth_taken", queue_level, 4);
    for (int n = 0; n < 300 && spans_done != 16'd8; n++) cyc();
    check("bp_drain", spans_done, 8);
    check("bp_order_len", rgbx_log.size(), 5);
    for (int i = 0; i < 5; i++) check("bp_order", rgbx_log[i], i + 1);
    check("bp_zsum", last_z_sum, 32'h1005);

    // Watchdog: engine never raises done.
    hang = 1'b1; s0 = starts;
    push(32'h40, 32'd2, 32'd2);
    cyc();
    check("wd_start", bus.eng_start, 1);
    cyc(101);
    check("wd_pre_terr", timeout_err, 0);
    check("wd_pre_busy", busy, 1);
    cyc();
    check("wd_terr", timeout_err, 1);
    check("wd_halt_busy", busy, 0);
    hang = 1'b0;
    push(32'h41, 32'd3, 32'd3);
    push(32'h42, 32'd4, 32'd4);
    cyc(3);
    check("wd_queue_level", queue_level, 2);
    check("wd_hold_desc", eng_all, desc(32'h40, 32'd2, 32'd2));
    check("wd_no_restart", starts - s0, 1);
    check("wd_sticky", timeout_err, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("wd_cleared", timeout_err, 0);
    cyc();
    check("wd_resume_start", bus.eng_start, 1);
    check("wd_resume_rgbx", bus.eng_rgbx, 32'h41);
    for (int n = 0; n < 100 && spans_done != 16'd10; n++) cyc();
    check("wd_drain", spans_done, 10);
    check("wd_zsum", last_z_sum, 32'h8);

    // Descriptor stability while cmd_* churns.
    delay = 30;
    push(32'h50, 32'h55, 32'h66);
    cyc();
    exp_d = desc(32'h50, 32'h55, 32'h66);
    check("stab_start", bus.eng_start, 1);
    for (int n = 0; n < 60 && busy; n++) begin
      set_cmd($urandom, $urandom, $urandom);
      check("stab_desc", eng_all, exp_d);
      cyc();
    end
    check("stab_retire_desc", eng_all, exp_d);
    cyc();
    check("stab_spans", spans_done, 11);
    check("stab_zsum", last_z_sum, 32'hBB);

    // Asynchronous reset mid-span with two entries queued.
    delay = 40;
    push(32'h61, 32'd1, 32'd1);
    push(32'h62, 32'd1, 32'd1);
    push(32'h63, 32'd1, 32'd1);
    cyc(3);
    check("ar_level", queue_level, 2);
    check("ar_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("ar");
    cyc();
    reset = 1'b0;
    cyc(3);
    check("ar_queue_lost", queue_level, 0);
    check("ar_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
